spi_frame_sender: RTL and testbench
===================================

// Module: spi_frame_sender
// PURPOSE
// - SPI master; the transmitting end of the image/control SPI link (alt low = image, alt high = control word).
// - Reads 64-bit words from a BRAM read port (addr 0..MAX_POS) or takes one control word; shifts them out MSB-first.
// - Drives a downstream panel board, or loops back into our own receiver for self-test.
// PARAMETERS
// - MAX_POS   8'd191  last BRAM address of an image frame (frame = MAX_POS+1 words)
// - HALF_DIV  4       clk cycles per SCLK half-period; legal 1..255
// - RD_LAT    1       BRAM read latency in clk cycles after the bram_en cycle; legal 1..3
// - GAP_CYC   8       alt-guard length in clk cycles, before and after each frame
// PORTS
// - clk          in   1   system clock (clk_20M domain)
// - rst          in   1   synchronous, active-high reset
// - start_img    in   1   1-cycle pulse: send image frame
// - start_ctrl   in   1   1-cycle pulse: send ctrl_word
// - ctrl_word    in   64  control word; sampled on the accepted start_ctrl cycle
// - bram_addr    out  8   BRAM read address
// - bram_en      out  1   BRAM read enable (ceb)
// - bram_data    in   64  BRAM read data, valid RD_LAT cycles after bram_en
// - busy         out  1   high from accepted start until DONE completes
// - done         out  1   1-cycle pulse when a frame completes
// - SPI_sclk     out  1   SPI clock; idles low
// - SPI_mosi     out  1   SPI data; changes on SCLK fall, stable at SCLK rise
// - SPI_alt      out  1   channel select / receiver position reset
// BEHAVIOUR
// - Reset values: SPI_sclk=0, SPI_mosi=0, SPI_alt=1, bram_en=0, bram_addr=0, busy=0, done=0; FSM=IDLE.
// - Reset mid-frame: outputs return to reset values on the next edge; the partial frame is abandoned.
// - Start acceptance: only in IDLE. Both starts in the same cycle: start_img wins. Starts while busy are ignored, not queued.
// - tgt (target alt level) = 0 for image, 1 for ctrl.
// - FSM states:
//   - IDLE -> PRE on an accepted start.
//   - PRE: SPI_alt = ~tgt for GAP_CYC cycles, then tgt for GAP_CYC cycles. The alt edge resets the target receiver's position.
//   - PRE -> FETCH (image) or LOAD (ctrl).
//   - FETCH: bram_en=1 for exactly 1 cycle at bram_addr; wait RD_LAT cycles; capture bram_data into shreg -> SHIFT.
//   - LOAD: shreg <= latched ctrl_word -> SHIFT.
//   - SHIFT: mosi = shreg[63] is set before the first rise. Each bit = HALF_DIV clk cycles low, then HALF_DIV high.
//     Shift left on each fall. After 64 rises SCLK returns low.
//   - SHIFT exit: image and bram_addr != MAX_POS -> bram_addr+1, FETCH; otherwise -> POST.
//   - POST: SCLK low, alt held at tgt for GAP_CYC cycles, then alt=1 -> DONE.
//   - DONE: done=1 for 1 cycle, busy deasserts in the same cycle -> IDLE.
// - SCLK stays low during FETCH, which creates inter-word gaps; the receiver must tolerate them because it is purely SCLK-driven.
// - Counters: 7-bit bit counter (0..64), 8-bit divider, 8-bit address; bram_addr never exceeds MAX_POS.
// - Image frame: exactly (MAX_POS+1)*64 SCLK rises. Ctrl frame: exactly 64 rises.
// - MAX_POS=0 gives a 1-word image frame, with no address increment.
// STRUCTURE
// - Shared package: SCLK_IDLE=0, ALT_IMG=0, ALT_CTRL=1, WORD_W=64, ADDR_W=8, FSM state encoding.
// - One sub-module, spi_bit_shifter: 64-bit shift register, divider, and bit counter.
//   Handshake: load/go in, bit_done out.
// - The FSM in this module owns alt, the BRAM port, and sequencing.
// TESTING
// 1. start_ctrl with ctrl_word=64'hA5A5_0000_FFFF_1234, HALF_DIV=4:
//    - alt goes 0 for 8 cycles, then 1; 64 rises at 8-cycle period.
//    - Bits sampled on rises = the word MSB-first; done pulses once.
// 2. start_img with MAX_POS=2 and BRAM model with RD_LAT=1, contents {0x0123..., 0xFEDC..., 0x5555...}:
//    - 192 rises, data in order, bram_en pulses 3 times at addr 0,1,2.
//    - alt low only in the frame window.
// 3. Loopback into the existing BRAM SPI receiver (MAX_POS=191), random 192-word image:
//    - Receiver writes addr 0..191 with identical data; no extra writes.
// 4. start_img and start_ctrl in the same cycle, then start_ctrl again mid-frame:
//    - Only the image frame is sent; exactly one done pulse.
// 5. rst asserted at bit 30 of word 5:
//    - Next cycle sclk=0, alt=1, busy=0.
//    - A new start_ctrl afterwards sends a clean 64-bit frame.
// 6. HALF_DIV=1 and RD_LAT=3, MAX_POS=0:
//    - SCLK toggles every clk; first bit equals bram_data captured 3 cycles after bram_en; 64 rises total.

Source files
------------

// File: rtl/spi_frame_sender_pkg.sv
// Shared constants and FSM encoding for the image/control SPI transmit link.
package spi_frame_sender_pkg;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic ALT_IMG   = 1'b0;
    localparam logic ALT_CTRL  = 1'b1;
    localparam int   WORD_W    = 64;
    localparam int   ADDR_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_POST,
        ST_DONE
    } state_t;
endpackage

// File: rtl/spi_frame_sender_bit_shifter.sv
// 64-bit MSB-first shifter with SCLK divider; shifts one word per load/go and pulses bit_done.
module spi_bit_shifter
    import spi_frame_sender_pkg::*;
#(
    parameter int HALF_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              go,
    output logic              sclk,
    output logic              mosi,
    output logic              bit_done
);
    localparam logic [7:0] DIV_LAST  = 8'(HALF_DIV - 1);
    localparam logic [6:0] BITS_LAST = 7'(WORD_W);

    logic [WORD_W-1:0] shreg;
    logic [7:0]        div_cnt;
    logic [6:0]        bit_cnt;
    logic              active;
    logic              fall_now;

    always_comb begin
        fall_now = active && (div_cnt == DIV_LAST) && (sclk != SCLK_IDLE);
    end

    always_ff @(posedge clk) begin
        if (load)
            shreg <= load_data;
        else if (fall_now)
            shreg <= {shreg[WORD_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            sclk     <= SCLK_IDLE;
            mosi     <= 1'b0;
            bit_done <= 1'b0;
            div_cnt  <= 8'd0;
            bit_cnt  <= 7'd0;
        end else begin
            bit_done <= 1'b0;
            if (load)
                mosi <= load_data[WORD_W-1];
            if (go) begin
                active  <= 1'b1;
                div_cnt <= 8'd0;
                bit_cnt <= 7'd0;
                sclk    <= SCLK_IDLE;
            end else if (active) begin
                if (div_cnt != DIV_LAST) begin
                    div_cnt <= div_cnt + 8'd1;
                end else begin
                    div_cnt <= 8'd0;
                    if (sclk == SCLK_IDLE) begin
                        sclk    <= ~SCLK_IDLE;
                        bit_cnt <= bit_cnt + 7'd1;
                    end else begin
                        sclk <= SCLK_IDLE;
                        // next bit appears on the fall so it is stable across the following rise
                        if (bit_cnt == BITS_LAST) begin
                            active   <= 1'b0;
                            bit_done <= 1'b1;
                            mosi     <= 1'b0;
                        end else begin
                            mosi <= shreg[WORD_W-2];
                        end
                    end
                end
            end
        end
    end
endmodule

// File: rtl/spi_frame_sender.sv
// SPI master for the image/control link: sequences alt guards, BRAM fetches and word shifts.
module spi_frame_sender
    import spi_frame_sender_pkg::*;
#(
    parameter logic [7:0] MAX_POS  = 8'd191,
    parameter int         HALF_DIV = 4,
    parameter int         RD_LAT   = 1,
    parameter int         GAP_CYC  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_img,
    input  logic              start_ctrl,
    input  logic [WORD_W-1:0] ctrl_word,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [WORD_W-1:0] bram_data,
    output logic              busy,
    output logic              done,
    output logic              SPI_sclk,
    output logic              SPI_mosi,
    output logic              SPI_alt
);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);
    localparam logic [1:0] RD_LAST  = 2'(RD_LAT);

    state_t            state;
    logic              tgt;
    logic              pre_phase;
    logic [7:0]        gap_cnt;
    logic [1:0]        rd_cnt;
    logic [WORD_W-1:0] ctrl_lat;
    logic              sh_load;
    logic [WORD_W-1:0] sh_data;
    logic              bit_done;

    always_comb begin
        sh_load = (state == ST_LOAD) || ((state == ST_FETCH) && (rd_cnt == RD_LAST));
        sh_data = (state == ST_LOAD) ? ctrl_lat : bram_data;
    end

    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && start_ctrl && !start_img)
            ctrl_lat <= ctrl_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tgt       <= ALT_CTRL;
            pre_phase <= 1'b0;
            gap_cnt   <= 8'd0;
            rd_cnt    <= 2'd0;
            bram_addr <= '0;
            bram_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            SPI_alt   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_img || start_ctrl) begin
                        tgt       <= start_img ? ALT_IMG : ALT_CTRL;
                        SPI_alt   <= start_img ? ~ALT_IMG : ~ALT_CTRL;
                        busy      <= 1'b1;
                        bram_addr <= '0;
                        gap_cnt   <= 8'd0;
                        pre_phase <= 1'b0;
                        state     <= ST_PRE;
                    end
                end
                // guard: ~tgt then tgt, the alt edge resets the receiver's word position
                ST_PRE: begin
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end else begin
                        gap_cnt <= 8'd0;
                        if (!pre_phase) begin
                            pre_phase <= 1'b1;
                            SPI_alt   <= tgt;
                        end else if (tgt == ALT_IMG) begin
                            bram_en <= 1'b1;
                            rd_cnt  <= 2'd0;
                            state   <= ST_FETCH;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_FETCH: begin
                    bram_en <= 1'b0;
                    if (rd_cnt == RD_LAST)
                        state <= ST_SHIFT;
                    else
                        rd_cnt <= rd_cnt + 2'd1;
                end
                ST_LOAD: state <= ST_SHIFT;
                ST_SHIFT: begin
                    if (bit_done) begin
                        if ((tgt == ALT_IMG) && (bram_addr != MAX_POS)) begin
                            bram_addr <= bram_addr + 8'd1;
                            bram_en   <= 1'b1;
                            rd_cnt    <= 2'd0;
                            state     <= ST_FETCH;
                        end else begin
                            gap_cnt <= 8'd0;
                            state   <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end else begin
                        SPI_alt <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    spi_bit_shifter #(
        .HALF_DIV (HALF_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_data (sh_data),
        .go        (sh_load),
        .sclk      (SPI_sclk),
        .mosi      (SPI_mosi),
        .bit_done  (bit_done)
    );
endmodule

// File: tb/tb_spi_frame_sender.sv
// Directed bench: three parameterisations of spi_frame_sender, each with a BRAM model and SPI receiver model.
module tb_spi_frame_sender;
    localparam logic [63:0] POISON = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // instance a: MAX_POS=2, HALF_DIV=4, RD_LAT=1
    logic rst_a = 1'b1, start_img_a = 1'b0, start_ctrl_a = 1'b0;
    logic [63:0] ctrl_word_a = '0, bram_data_a;
    logic [7:0] bram_addr_a;
    logic bram_en_a, busy_a, done_a, sclk_a, mosi_a, alt_a;
    // instance b: MAX_POS=191, HALF_DIV=1, RD_LAT=1
    logic rst_b = 1'b1, start_img_b = 1'b0, start_ctrl_b = 1'b0;
    logic [63:0] ctrl_word_b = '0, bram_data_b;
    logic [7:0] bram_addr_b;
    logic bram_en_b, busy_b, done_b, sclk_b, mosi_b, alt_b;
    // instance c: MAX_POS=0, HALF_DIV=1, RD_LAT=3
    logic rst_c = 1'b1, start_img_c = 1'b0, start_ctrl_c = 1'b0;
    logic [63:0] ctrl_word_c = '0, bram_data_c;
    logic [7:0] bram_addr_c;
    logic bram_en_c, busy_c, done_c, sclk_c, mosi_c, alt_c;

    spi_frame_sender #(.MAX_POS(8'd2), .HALF_DIV(4), .RD_LAT(1), .GAP_CYC(8)) u_a (
        .clk(clk), .rst(rst_a), .start_img(start_img_a), .start_ctrl(start_ctrl_a),
        .ctrl_word(ctrl_word_a), .bram_addr(bram_addr_a), .bram_en(bram_en_a),
        .bram_data(bram_data_a), .busy(busy_a), .done(done_a),
        .SPI_sclk(sclk_a), .SPI_mosi(mosi_a), .SPI_alt(alt_a));
    spi_frame_sender #(.MAX_POS(8'd191), .HALF_DIV(1), .RD_LAT(1), .GAP_CYC(8)) u_b (
        .clk(clk), .rst(rst_b), .start_img(start_img_b), .start_ctrl(start_ctrl_b),
        .ctrl_word(ctrl_word_b), .bram_addr(bram_addr_b), .bram_en(bram_en_b),
        .bram_data(bram_data_b), .busy(busy_b), .done(done_b),
        .SPI_sclk(sclk_b), .SPI_mosi(mosi_b), .SPI_alt(alt_b));
    spi_frame_sender #(.MAX_POS(8'd0), .HALF_DIV(1), .RD_LAT(3), .GAP_CYC(8)) u_c (
        .clk(clk), .rst(rst_c), .start_img(start_img_c), .start_ctrl(start_ctrl_c),
        .ctrl_word(ctrl_word_c), .bram_addr(bram_addr_c), .bram_en(bram_en_c),
        .bram_data(bram_data_c), .busy(busy_c), .done(done_c),
        .SPI_sclk(sclk_c), .SPI_mosi(mosi_c), .SPI_alt(alt_c));

    // BRAM models: data only valid exactly RD_LAT cycles after the enable cycle
    logic [63:0] mem_a [3];
    logic [63:0] mem_b [192];
    logic [63:0] mem_c [1];
    logic en_a_q = 1'b0, en_b_q = 1'b0;
    logic [7:0] ad_a_q = '0, ad_b_q = '0;
    logic [2:0] en_c_p = '0;
    always @(posedge clk) begin
        en_a_q <= bram_en_a; ad_a_q <= bram_addr_a;
        en_b_q <= bram_en_b; ad_b_q <= bram_addr_b;
        en_c_p <= {en_c_p[1:0], bram_en_c};
    end
    assign bram_data_a = (en_a_q && ad_a_q < 8'd3) ? mem_a[ad_a_q[1:0]] : POISON;
    assign bram_data_b = (en_b_q && ad_b_q < 8'd192) ? mem_b[ad_b_q] : POISON;
    assign bram_data_c = en_c_p[2] ? mem_c[0] : POISON;

    // receiver/monitor models: sample on SCLK rises, alt edge resets word position
    int rises_a = 0, ralt1_a = 0, alt0_a = 0, alt0idle_a = 0, dones_a = 0, bp_a = 0;
    int rises_b = 0, ralt1_b = 0, alt0_b = 0, alt0idle_b = 0, dones_b = 0, bp_b = 0;
    int rises_c = 0, ralt1_c = 0, alt0_c = 0, alt0idle_c = 0, dones_c = 0, bp_c = 0;
    logic sclk_a_q = 1'b0, alt_a_q = 1'b1, sclk_b_q = 1'b0, alt_b_q = 1'b1, sclk_c_q = 1'b0, alt_c_q = 1'b1;
    logic [63:0] sh_a = '0, sh_b = '0, sh_c = '0;
    logic [63:0] words_a[$], words_b[$], words_c[$];
    logic [7:0] ens_a[$], ens_b[$], ens_c[$];
    int rc_a[$], rc_c[$];

    always @(negedge clk) begin
        if (alt_a !== alt_a_q) bp_a = 0;
        if (sclk_a && !sclk_a_q) begin
            rises_a++; rc_a.push_back(cyc);
            if (alt_a) ralt1_a++;
            sh_a = {sh_a[62:0], mosi_a}; bp_a++;
            if (bp_a == 64) begin words_a.push_back(sh_a); bp_a = 0; end
        end
        if (!alt_a) alt0_a++;
        if (!alt_a && !busy_a) alt0idle_a++;
        if (done_a) dones_a++;
        if (bram_en_a) ens_a.push_back(bram_addr_a);
        sclk_a_q = sclk_a; alt_a_q = alt_a;
    end
    always @(negedge clk) begin
        if (alt_b !== alt_b_q) bp_b = 0;
        if (sclk_b && !sclk_b_q) begin
            rises_b++;
            if (alt_b) ralt1_b++;
            sh_b = {sh_b[62:0], mosi_b}; bp_b++;
            if (bp_b == 64) begin words_b.push_back(sh_b); bp_b = 0; end
        end
        if (!alt_b) alt0_b++;
        if (!alt_b && !busy_b) alt0idle_b++;
        if (done_b) dones_b++;
        if (bram_en_b) ens_b.push_back(bram_addr_b);
        sclk_b_q = sclk_b; alt_b_q = alt_b;
    end
    always @(negedge clk) begin
        if (alt_c !== alt_c_q) bp_c = 0;
        if (sclk_c && !sclk_c_q) begin
            rises_c++; rc_c.push_back(cyc);
            if (alt_c) ralt1_c++;
            sh_c = {sh_c[62:0], mosi_c}; bp_c++;
            if (bp_c == 64) begin words_c.push_back(sh_c); bp_c = 0; end
        end
        if (!alt_c) alt0_c++;
        if (!alt_c && !busy_c) alt0idle_c++;
        if (done_c) dones_c++;
        if (bram_en_c) ens_c.push_back(bram_addr_c);
        sclk_c_q = sclk_c; alt_c_q = alt_c;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    task automatic wait_done(input int sel, input int budget, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_of(sel)) begin seen = 1'b1; break; end
        end
        chk(tag, 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    int b_r, b_r1, b_a0, b_ai, b_d, b_w, b_e, b_rc, mism;
    logic reached;

    initial begin
        mem_a[0] = 64'h0123_4567_89AB_CDEF;
        mem_a[1] = 64'hFEDC_BA98_7654_3210;
        mem_a[2] = 64'h5555_5555_5555_5555;
        for (int i = 0; i < 192; i++) mem_b[i] = {$urandom, $urandom};
        mem_c[0] = 64'hC3A5_9617_E82D_4B0F;

        repeat (4) @(negedge clk);
        chk("rst_sclk", 64'(sclk_a), 64'd0);
        chk("rst_mosi", 64'(mosi_a), 64'd0);
        chk("rst_alt", 64'(alt_a), 64'd1);
        chk("rst_bram_en", 64'(bram_en_a), 64'd0);
        chk("rst_bram_addr", 64'(bram_addr_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (2) @(negedge clk);

        // 1: control word on instance a
        b_r = rises_a; b_r1 = ralt1_a; b_a0 = alt0_a; b_ai = alt0idle_a;
        b_d = dones_a; b_w = words_a.size(); b_e = ens_a.size(); b_rc = rc_a.size();
        ctrl_word_a = 64'hA5A5_0000_FFFF_1234; start_ctrl_a = 1'b1;
        @(negedge clk); start_ctrl_a = 1'b0; ctrl_word_a = '0;
        chk("t1_busy", 64'(busy_a), 64'd1);
        wait_done(0, 2000, "t1_done_seen");
        chk("t1_rises", 64'(rises_a - b_r), 64'd64);
        chk("t1_alt_high_at_rises", 64'(ralt1_a - b_r1), 64'd64);
        chk("t1_alt_low_cycles", 64'(alt0_a - b_a0), 64'd8);
        chk("t1_alt_low_idle", 64'(alt0idle_a - b_ai), 64'd0);
        chk("t1_done_pulses", 64'(dones_a - b_d), 64'd1);
        chk("t1_bram_en", 64'(ens_a.size() - b_e), 64'd0);
        chk("t1_words", 64'(words_a.size() - b_w), 64'd1);
        if (words_a.size() > b_w) chk("t1_word", words_a[b_w], 64'hA5A5_0000_FFFF_1234);
        if (rc_a.size() >= b_rc + 64) chk("t1_period", 64'(rc_a[b_rc + 63] - rc_a[b_rc]), 64'd504);
        chk("t1_busy_end", 64'(busy_a), 64'd0);
        chk("t1_alt_end", 64'(alt_a), 64'd1);

        // 2: three-word image on instance a
        b_r = rises_a; b_r1 = ralt1_a; b_ai = alt0idle_a;
        b_d = dones_a; b_w = words_a.size(); b_e = ens_a.size();
        start_img_a = 1'b1; @(negedge clk); start_img_a = 1'b0;
        wait_done(0, 3000, "t2_done_seen");
        chk("t2_rises", 64'(rises_a - b_r), 64'd192);
        chk("t2_alt_high_at_rises", 64'(ralt1_a - b_r1), 64'd0);
        chk("t2_alt_low_idle", 64'(alt0idle_a - b_ai), 64'd0);
        chk("t2_done_pulses", 64'(dones_a - b_d), 64'd1);
        chk("t2_bram_en", 64'(ens_a.size() - b_e), 64'd3);
        for (int i = 0; i < 3; i++)
            if (ens_a.size() > b_e + i) chk($sformatf("t2_addr%0d", i), 64'(ens_a[b_e + i]), 64'(i));
        chk("t2_words", 64'(words_a.size() - b_w), 64'd3);
        for (int i = 0; i < 3; i++)
            if (words_a.size() > b_w + i) chk($sformatf("t2_word%0d", i), words_a[b_w + i], mem_a[i]);

        // 4: simultaneous starts, then ignored start_ctrl mid-frame
        b_r = rises_a; b_r1 = ralt1_a; b_d = dones_a; b_w = words_a.size();
        ctrl_word_a = 64'h1111_2222_3333_4444;
        start_img_a = 1'b1; start_ctrl_a = 1'b1;
        @(negedge clk); start_img_a = 1'b0; start_ctrl_a = 1'b0;
        repeat (300) @(negedge clk);
        start_ctrl_a = 1'b1; @(negedge clk); start_ctrl_a = 1'b0;
        wait_done(0, 3000, "t4_done_seen");
        repeat (600) @(negedge clk);
        chk("t4_rises", 64'(rises_a - b_r), 64'd192);
        chk("t4_alt_high_at_rises", 64'(ralt1_a - b_r1), 64'd0);
        chk("t4_done_pulses", 64'(dones_a - b_d), 64'd1);
        chk("t4_words", 64'(words_a.size() - b_w), 64'd3);
        for (int i = 0; i < 3; i++)
            if (words_a.size() > b_w + i) chk($sformatf("t4_word%0d", i), words_a[b_w + i], mem_a[i]);

        // 3: full 192-word image on instance b, checked by the receiver model
        b_d = dones_b; b_w = words_b.size(); b_e = ens_b.size(); b_ai = alt0idle_b;
        start_img_b = 1'b1; @(negedge clk); start_img_b = 1'b0;
        wait_done(1, 40000, "t3_done_seen");
        chk("t3_words", 64'(words_b.size() - b_w), 64'd192);
        chk("t3_bram_en", 64'(ens_b.size() - b_e), 64'd192);
        chk("t3_done_pulses", 64'(dones_b - b_d), 64'd1);
        chk("t3_alt_low_idle", 64'(alt0idle_b - b_ai), 64'd0);
        mism = 0;
        for (int i = 0; i < 192; i++) begin
            if (words_b.size() <= b_w + i || words_b[b_w + i] !== mem_b[i]) mism++;
            if (ens_b.size() <= b_e + i || ens_b[b_e + i] !== 8'(i)) mism++;
        end
        chk("t3_data_addr_mismatches", 64'(mism), 64'd0);

        // 5: reset at bit 30 of word 5, then a clean control frame
        b_r = rises_b;
        start_img_b = 1'b1; @(negedge clk); start_img_b = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (rises_b - b_r >= 5 * 64 + 30) begin reached = 1'b1; break; end
        end
        chk("t5_reached_bit", 64'(reached), 64'd1);
        rst_b = 1'b1; @(negedge clk);
        chk("t5_sclk", 64'(sclk_b), 64'd0);
        chk("t5_alt", 64'(alt_b), 64'd1);
        chk("t5_busy", 64'(busy_b), 64'd0);
        chk("t5_bram_en", 64'(bram_en_b), 64'd0);
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        b_r = rises_b; b_w = words_b.size(); b_d = dones_b;
        ctrl_word_b = 64'h0F1E_2D3C_4B5A_6978; start_ctrl_b = 1'b1;
        @(negedge clk); start_ctrl_b = 1'b0; ctrl_word_b = '0;
        wait_done(1, 2000, "t5_done_seen");
        chk("t5_rises", 64'(rises_b - b_r), 64'd64);
        chk("t5_done_pulses", 64'(dones_b - b_d), 64'd1);
        chk("t5_words", 64'(words_b.size() - b_w), 64'd1);
        if (words_b.size() > b_w) chk("t5_word", words_b[b_w], 64'h0F1E_2D3C_4B5A_6978);

        // 6: HALF_DIV=1, RD_LAT=3, single-word image on instance c
        b_r = rises_c; b_w = words_c.size(); b_e = ens_c.size(); b_rc = rc_c.size(); b_d = dones_c;
        start_img_c = 1'b1; @(negedge clk); start_img_c = 1'b0;
        wait_done(2, 1000, "t6_done_seen");
        chk("t6_rises", 64'(rises_c - b_r), 64'd64);
        chk("t6_bram_en", 64'(ens_c.size() - b_e), 64'd1);
        if (ens_c.size() > b_e) chk("t6_addr", 64'(ens_c[b_e]), 64'd0);
        chk("t6_done_pulses", 64'(dones_c - b_d), 64'd1);
        chk("t6_words", 64'(words_c.size() - b_w), 64'd1);
        if (words_c.size() > b_w) chk("t6_word", words_c[b_w], 64'hC3A5_9617_E82D_4B0F);
        if (rc_c.size() >= b_rc + 64) chk("t6_period", 64'(rc_c[b_rc + 63] - rc_c[b_rc]), 64'd126);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
